lh_pulse_capture: RTL

Multi-channel successor to the single-envelope pulse timer, for lighthouse sensor front-ends. Each channel synchronises its envelope input, measures high-pulse width in clk cycles, and timestamps the rising edge against a shared free-running timebase. Short glitches are rejected. Completed records are queued one-deep per channel and drained through a single valid/ready output port with fixed-priority arbitration, feeding the sweep/sync decoder.

---
 rtl/lh_pulse_capture.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/lh_pulse_capture.sv
// lh_pulse_capture: multi-channel envelope pulse timer. Each channel keeps a one-deep
// record slot. A fixed-priority valid/ready register drains the slots.
module lh_pulse_capture #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = 2,
  parameter int MIN_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] envelope,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_BITS-1:0]  out_channel,
  output logic [WIDTH-1:0]    out_start,
  output logic [WIDTH-1:0]    out_width,
  output logic                out_sat,
  output logic [CHANNELS-1:0] overrun
);
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HIGH = 1'b1;
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_WIDTH);
  localparam logic FILTER_ON = (MIN_WIDTH > 1);

  logic [WIDTH-1:0]    r_timebase;
  logic [CHANNELS-1:0] r_sync1, r_s, r_prev, r_armed, r_state, r_pend;
  logic [1:0]          r_settle;
  logic [WIDTH-1:0]    r_cnt        [CHANNELS];
  logic [WIDTH-1:0]    r_start      [CHANNELS];
  logic [CHANNELS-1:0] r_sat;
  logic [WIDTH-1:0]    r_slot_start [CHANNELS];
  logic [WIDTH-1:0]    r_slot_width [CHANNELS];
  logic [CHANNELS-1:0] r_slot_sat;

  logic [CHANNELS-1:0] w_rise, w_fall, w_rec, w_lowest, w_grant;
  logic                w_load, w_any, w_mux_sat;
  logic [CH_BITS-1:0]  w_sel;
  logic [WIDTH-1:0]    w_mux_start, w_mux_width;

  // Edge detection, record qualification and lowest-index-pending selection.
  always_comb begin
    w_rise      = r_s & ~r_prev;
    w_fall      = ~r_s & r_prev;
    w_load      = !out_valid || out_ready;
    w_any       = |r_pend;
    w_lowest    = r_pend & (~r_pend + CHANNELS'(1));
    w_grant     = w_load ? w_lowest : '0;
    w_rec       = '0;
    w_sel       = '0;
    w_mux_start = '0;
    w_mux_width = '0;
    w_mux_sat   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rec[i]    = (r_state[i] == ST_HIGH) && w_fall[i] &&
                    (!FILTER_ON || (r_cnt[i] >= MIN_W));
      w_sel       = w_sel | (w_lowest[i] ? CH_BITS'(i) : '0);
      w_mux_start = w_mux_start | (w_lowest[i] ? r_slot_start[i] : '0);
      w_mux_width = w_mux_width | (w_lowest[i] ? r_slot_width[i] : '0);
      w_mux_sat   = w_mux_sat | (w_lowest[i] & r_slot_sat[i]);
    end
  end

  // Timebase, synchronisers, per-channel measurement FSM and record slots.
  // r_settle masks the two cycles where r_s still shows reset values, so a pulse
  // already high at reset cannot arm the channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timebase <= '0;
      r_sync1    <= '0;
      r_s        <= '0;
      r_prev     <= '0;
      r_settle   <= 2'b00;
      r_armed    <= '0;
      r_state    <= '0;
      r_sat      <= '0;
      r_pend     <= '0;
      r_slot_sat <= '0;
      overrun    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]        <= '0;
        r_start[i]      <= '0;
        r_slot_start[i] <= '0;
        r_slot_width[i] <= '0;
      end
    end else begin
      r_timebase <= r_timebase + CNT_ONE;
      r_sync1    <= envelope;
      r_s        <= r_sync1;
      r_prev     <= r_s;
      r_settle   <= {r_settle[0], 1'b1};
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_settle[1] && !r_s[i]) begin
          r_armed[i] <= 1'b1;
        end
        case (r_state[i])
          ST_IDLE: begin
            if (w_rise[i] && r_armed[i]) begin
              r_state[i] <= ST_HIGH;
              r_start[i] <= r_timebase;
              r_cnt[i]   <= CNT_ONE;
              r_sat[i]   <= 1'b0;
            end
          end
          ST_HIGH: begin
            if (w_fall[i]) begin
              r_state[i] <= ST_IDLE;
            end else if (r_s[i]) begin
              if (r_cnt[i] == CNT_MAX) begin
                r_sat[i] <= 1'b1;
              end else begin
                r_cnt[i] <= r_cnt[i] + CNT_ONE;
              end
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
        if (w_rec[i]) begin
          if (!r_pend[i] || w_grant[i]) begin
            r_pend[i]       <= 1'b1;
            r_slot_start[i] <= r_start[i];
            r_slot_width[i] <= r_cnt[i];
            r_slot_sat[i]   <= r_sat[i];
          end else begin
            overrun[i] <= 1'b1;
          end
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Output register: reloads whenever empty or being accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_start   <= '0;
      out_width   <= '0;
      out_sat     <= 1'b0;
    end else if (w_load) begin
      out_valid <= w_any;
      if (w_any) begin
        out_channel <= w_sel;
        out_start   <= w_mux_start;
        out_width   <= w_mux_width;
        out_sat     <= w_mux_sat;
      end
    end
  end
endmodule
